// File: rtl/skew_delay_buf.sv
// Multi-lane programmable delay line. Each lane is a shift register of
// {valid, data}. The output tap sits at stage L_c-1, where
// L_c = delay + (skew ? c : 0). The tap is registered from the next-state
// value, so q is a flop output with no added latency.
module skew_delay_buf #(
    parameter int  CHANNELS      = 4,
    parameter int  BITS          = 8,
    parameter int  MAX_DELAY     = 8,
    parameter int  DEFAULT_DELAY = 2,
    parameter bit  DEFAULT_SKEW  = 1'b0,
    localparam int DW            = $clog2(MAX_DELAY + 1),
    localparam int SD            = MAX_DELAY + CHANNELS - 1,
    localparam int IW            = (SD > 1) ? $clog2(SD) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     d_valid,
    input  logic [CHANNELS*BITS-1:0] d,
    input  logic                     cfg_wr,
    input  logic [DW-1:0]            cfg_delay,
    input  logic                     cfg_skew,
    output logic [CHANNELS*BITS-1:0] q,
    output logic [CHANNELS-1:0]      q_valid,
    output logic                     busy,
    output logic                     cfg_err
);

    logic [BITS-1:0]          data_q  [CHANNELS][SD];
    logic [BITS-1:0]          data_d  [CHANNELS][SD];
    logic [SD-1:0]            valid_q [CHANNELS];
    logic [SD-1:0]            valid_d [CHANNELS];
    logic [DW-1:0]            delay_q, delay_d;
    logic                     skew_q, skew_d;
    logic [CHANNELS*BITS-1:0] q_q, q_d;
    logic [CHANNELS-1:0]      q_valid_q, q_valid_d;
    logic                     cfg_err_q, cfg_err_d;

    logic [IW-1:0]            tap_cur_s [CHANNELS];
    logic [IW-1:0]            tap_nxt_s [CHANNELS];
    logic                     busy_s;
    logic                     cfg_accept_s;
    logic                     advance_s;
    logic                     clear_s;

    // Tap positions for the active config (busy) and the next-cycle config (q).
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            tap_cur_s[c] = IW'(delay_q) + (skew_q ? IW'(c) : {IW{1'b0}}) - IW'(1);
            tap_nxt_s[c] = IW'(delay_d) + (skew_d ? IW'(c) : {IW{1'b0}}) - IW'(1);
        end
    end

    // busy: any valid sample at or before the tap of its lane.
    always_comb begin
        busy_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s < SD; s++) begin
                if (IW'(s) <= tap_cur_s[c]) begin
                    busy_s = busy_s | valid_q[c][s];
                end else begin
                    busy_s = busy_s;
                end
            end
        end
    end

    // Config acceptance: the delay must be in range, and the lanes must be idle
    // unless a flush empties them in the same cycle.
    always_comb begin
        cfg_accept_s = cfg_wr && (cfg_delay >= DW'(1)) && (cfg_delay <= DW'(MAX_DELAY))
                       && (!busy_s || flush);
        cfg_err_d    = cfg_wr && !cfg_accept_s;
        advance_s    = en && !flush && !cfg_accept_s;
        clear_s      = flush || cfg_accept_s;
        if (cfg_accept_s) begin
            delay_d = cfg_delay;
            skew_d  = cfg_skew;
        end else begin
            delay_d = delay_q;
            skew_d  = skew_q;
        end
    end

    // Pipeline next state: shift on advance, drop valids on clear, else hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (advance_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                data_d[c][0]  = d[c*BITS +: BITS];
                valid_d[c][0] = d_valid;
                for (int s = 1; s < SD; s++) begin
                    data_d[c][s]  = data_q[c][s-1];
                    valid_d[c][s] = valid_q[c][s-1];
                end
            end
        end else if (clear_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                valid_d[c] = {SD{1'b0}};
            end
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
        end
    end

    // Output tap registered from next-state pipeline and config.
    always_comb begin
        q_d       = {(CHANNELS*BITS){1'b0}};
        q_valid_d = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            q_d[c*BITS +: BITS] = data_d[c][tap_nxt_s[c]];
            q_valid_d[c]        = valid_d[c][tap_nxt_s[c]];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '{default: '0};
            valid_q   <= '{default: '0};
            delay_q   <= DW'(DEFAULT_DELAY);
            skew_q    <= DEFAULT_SKEW;
            q_q       <= {(CHANNELS*BITS){1'b0}};
            q_valid_q <= {CHANNELS{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            delay_q   <= delay_d;
            skew_q    <= skew_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = busy_s;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_skew_delay_buf.sv
// Scoreboard bench for skew_delay_buf (4 lanes x 8 bits, MAX_DELAY 8).
// Stimulus pushes hand-computed {cycle, data} expectations per lane. A
// negedge monitor pops and compares whenever a lane presents q_valid.
module tb_skew_delay_buf;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        d_valid;
    logic [31:0] d;
    logic        cfg_wr;
    logic [3:0]  cfg_delay;
    logic        cfg_skew;
    logic [31:0] q;
    logic [3:0]  q_valid;
    logic        busy;
    logic        cfg_err;

    int   cyc;
    int   checks;
    int   errors;
    int   t0;
    exp_t exp_q [4][$];

    skew_delay_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .d_valid  (d_valid),
        .d        (d),
        .cfg_wr   (cfg_wr),
        .cfg_delay(cfg_delay),
        .cfg_skew (cfg_skew),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter; cycle t spans posedge t to posedge t+1.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_all(input int base, input logic [31:0] v, input bit skew);
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.cyc  = base + (skew ? c : 0);
            e.data = v[c*8 +: 8];
            exp_q[c].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        d_valid = 1'b0;
        cfg_wr  = 1'b0;
        flush   = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Monitor: pop and compare on each valid lane, flag missed expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 4; c++) begin
                if (q_valid[c]) begin
                    checks = checks + 1;
                    if (exp_q[c].size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL unexpected_valid lane %0d actual=%0h required=none (cycle %0d)",
                                 c, q[c*8 +: 8], cyc);
                    end else begin
                        exp_t e;
                        e = exp_q[c].pop_front();
                        if (e.cyc != cyc || e.data !== q[c*8 +: 8]) begin
                            errors = errors + 1;
                            $display("FAIL lane_out %0d actual=%0h@%0d required=%0h@%0d",
                                     c, q[c*8 +: 8], cyc, e.data, e.cyc);
                        end
                    end
                end else if (exp_q[c].size() > 0 && exp_q[c][0].cyc <= cyc) begin
                    exp_t e;
                    e = exp_q[c].pop_front();
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL missed_valid lane %0d actual=none required=%0h@%0d (cycle %0d)",
                             c, e.data, e.cyc, cyc);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = 32'h0;
        cfg_wr = 1'b0; cfg_delay = 4'd0; cfg_skew = 1'b0;

        // Reset state, then idle.
        tick();
        @(negedge clk);
        chk("rst_q", q, 32'h0);
        chk("rst_q_valid", {28'h0, q_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cfg_err", {31'h0, cfg_err}, 32'h0);
        tick();
        rst_n = 1'b1;
        idle(2);
        @(negedge clk);
        chk("idle_q_valid", {28'h0, q_valid}, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Default delay 2: single sample.
        tick();
        t0 = cyc; en = 1'b1; d = 32'h44332211; d_valid = 1'b1;
        push_all(t0 + 2, 32'h44332211, 1'b0);
        @(negedge clk); chk("busy_c0", {31'h0, busy}, 32'h0);
        tick(); d_valid = 1'b0;
        @(negedge clk); chk("busy_c1", {31'h0, busy}, 32'h1);
        tick();
        @(negedge clk); chk("busy_c2", {31'h0, busy}, 32'h1);
        tick();
        @(negedge clk); chk("busy_c3", {31'h0, busy}, 32'h0);

        // Delay 3 with skew: lane c at 3+c.
        tick(); cfg_wr = 1'b1; cfg_delay = 4'd3; cfg_skew = 1'b1;
        tick(); cfg_wr = 1'b0;
        t0 = cyc; d = 32'h44332211; d_valid = 1'b1;
        push_all(t0 + 3, 32'h44332211, 1'b1);
        @(negedge clk); chk("cfg_ok_err", {31'h0, cfg_err}, 32'h0);
        tick(); d_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("busy_skew", {31'h0, busy}, (k <= 6) ? 32'h1 : 32'h0);
            tick();
        end

        // Delay 3, no skew, en low for two cycles: exits at cycle 5.
        cfg_wr = 1'b1; cfg_delay = 4'd3; cfg_skew = 1'b0;
        tick(); cfg_wr = 1'b0;
        t0 = cyc; d = 32'hA3A2A1A0; d_valid = 1'b1;
        push_all(t0 + 5, 32'hA3A2A1A0, 1'b0);
        tick(); en = 1'b0; d_valid = 1'b0;
        tick();
        tick(); en = 1'b1;
        idle(4);

        // Reject while busy; the in-flight sample keeps delay 3.
        t0 = cyc; d = 32'hB3B2B1B0; d_valid = 1'b1;
        push_all(t0 + 3, 32'hB3B2B1B0, 1'b0);
        tick(); d_valid = 1'b0; cfg_wr = 1'b1; cfg_delay = 4'd5;
        @(negedge clk); chk("busy_rej", {31'h0, busy}, 32'h1);
        tick(); cfg_wr = 1'b0;
        @(negedge clk); chk("err_busy", {31'h0, cfg_err}, 32'h1);
        tick();
        @(negedge clk); chk("err_clear", {31'h0, cfg_err}, 32'h0);
        idle(3);

        // Out-of-range rejects back to back; delay stays 3.
        cfg_wr = 1'b1; cfg_delay = 4'd0;
        tick(); cfg_delay = 4'd9;
        @(negedge clk); chk("err_zero", {31'h0, cfg_err}, 32'h1);
        tick(); cfg_wr = 1'b0;
        t0 = cyc; d = 32'hC3C2C1C0; d_valid = 1'b1;
        push_all(t0 + 3, 32'hC3C2C1C0, 1'b0);
        @(negedge clk); chk("err_nine", {31'h0, cfg_err}, 32'h1);
        tick(); d_valid = 1'b0;
        @(negedge clk); chk("err_done", {31'h0, cfg_err}, 32'h0);
        idle(5);

        // Flush kills the in-flight sample and the one offered with it.
        d = 32'hD3D2D1D0; d_valid = 1'b1;
        tick(); flush = 1'b1; d = 32'hE3E2E1E0;
        @(negedge clk); chk("busy_pre_flush", {31'h0, busy}, 32'h1);
        tick(); flush = 1'b0; d_valid = 1'b0;
        @(negedge clk); chk("busy_flushed", {31'h0, busy}, 32'h0);
        idle(6);

        // Asynchronous reset mid-flight, then defaults resume.
        d = 32'hF3F2F1F0; d_valid = 1'b1;
        tick(); d_valid = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_q", q, 32'h0);
        chk("arst_q_valid", {28'h0, q_valid}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        tick();
        tick(); rst_n = 1'b1;
        tick();
        t0 = cyc; d = 32'h87654321; d_valid = 1'b1;
        push_all(t0 + 2, 32'h87654321, 1'b0);
        tick(); d_valid = 1'b0;
        idle(5);

        for (int c = 0; c < 4; c++) begin
            checks = checks + 1;
            if (exp_q[c].size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain lane %0d actual=%0d pending required=0", c, exp_q[c].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
